// File: rtl/stream_parity_acc.sv
`default_nettype none
// ============================================================================
// Module     : stream_parity_acc
// Description: Folds FRAME_LEN stream words into one parity bit per frame and
//              holds the result until the consumer accepts it. Defining
//              PARITY_CHECK_EN adds an expected-parity compare (err/err_sticky).
// Revision   : 1.0 - initial release
// ============================================================================
module stream_parity_acc #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int ODD       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [7:0]       frame_cnt
`ifdef PARITY_CHECK_EN
    ,
    input  logic             exp_parity,
    output logic             err,
    output logic             err_sticky
`endif
);

    localparam int              CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic            ODD_BIT  = (ODD != 0);

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_parity_q, out_parity_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    logic w_accept;
    logic w_last;
    logic w_frame_par;

    assign w_accept    = in_valid && (state_q == ACC);
    assign w_last      = (cnt_q == LAST_CNT);
    assign w_frame_par = acc_q ^ (^in_data) ^ ODD_BIT;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_parity_d = out_parity_q;
        frame_cnt_d  = frame_cnt_q;
        case (state_q)
            ACC: begin
                if (w_accept) begin
                    if (w_last) begin
                        out_parity_d = w_frame_par;
                        out_valid_d  = 1'b1;
                        acc_d        = 1'b0;
                        cnt_d        = '0;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                        state_d      = HOLD;
                    end else begin
                        acc_d = acc_q ^ (^in_data);
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // Result stays frozen until the consumer takes it.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACC;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_parity_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_parity_q <= out_parity_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign in_ready   = (state_q == ACC);
    assign out_valid  = out_valid_q;
    assign out_parity = out_parity_q;
    assign frame_cnt  = frame_cnt_q;

`ifdef PARITY_CHECK_EN
    logic err_q, err_d;
    logic err_sticky_q, err_sticky_d;

    always_comb begin
        err_d        = err_q;
        err_sticky_d = err_sticky_q;
        if (w_accept && w_last) begin
            err_d        = (exp_parity != w_frame_par);
            err_sticky_d = err_sticky_q | (exp_parity != w_frame_par);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err        = err_q;
    assign err_sticky = err_sticky_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_parity_acc.sv
`default_nettype none
// ============================================================================
// Module     : tb_stream_parity_acc
// Description: Scoreboard bench for stream_parity_acc (even and odd instances).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_stream_parity_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       in_ready, out_valid, out_parity;
    logic [7:0] frame_cnt;
    logic       o_in_ready, o_out_valid, o_out_parity;
    logic [7:0] o_frame_cnt;
`ifdef PARITY_CHECK_EN
    logic exp_parity;
    logic err, err_sticky, o_err, o_err_sticky;
`endif

    int checks = 0;
    int errors = 0;

    logic       q_par[$];
    logic [7:0] q_fc[$];
    logic [7:0] fcnt_model = 8'd0;

    always #5 clk = ~clk;

    stream_parity_acc #(.WIDTH(8), .FRAME_LEN(4), .ODD(0)) u_even (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_parity(out_parity), .frame_cnt(frame_cnt)
`ifdef PARITY_CHECK_EN
        , .exp_parity(exp_parity), .err(err), .err_sticky(err_sticky)
`endif
    );

    stream_parity_acc #(.WIDTH(8), .FRAME_LEN(4), .ODD(1)) u_odd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(o_in_ready), .out_valid(o_out_valid), .out_ready(out_ready),
        .out_parity(o_out_parity), .frame_cnt(o_frame_cnt)
`ifdef PARITY_CHECK_EN
        , .exp_parity(exp_parity), .err(o_err), .err_sticky(o_err_sticky)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one pop per result, taken when out_valid rises.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (q_par.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                logic       ep;
                logic [7:0] ef;
                ep = q_par.pop_front();
                ef = q_fc.pop_front();
                chk("even_parity", {31'd0, out_parity}, {31'd0, ep});
                chk("odd_parity", {31'd0, o_out_parity}, {31'd0, ~ep});
                chk("odd_valid", {31'd0, o_out_valid}, 32'd1);
                chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, ef});
            end
        end
        prev_valid = out_valid;
    end

    task automatic send(input logic [7:0] d);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk("in_ready_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3,
                         input logic exp_par);
        fcnt_model = fcnt_model + 8'd1;
        q_par.push_back(exp_par);
        q_fc.push_back(fcnt_model);
        send(w0); send(w1); send(w2); send(w3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fcnt_model = 8'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
`ifdef PARITY_CHECK_EN
        exp_parity = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_parity", {31'd0, out_parity}, 32'd0);
        chk("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);

        // Basic frame: ^ = 1,0,0,0 -> even 1, odd 0; valid one cycle after last accept.
        frame(8'h01, 8'h03, 8'h00, 8'hFF, 1'b1);
        chk("lat_valid_high", {31'd0, out_valid}, 32'd1);
        chk("lat_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("lat_valid_low", {31'd0, out_valid}, 32'd0);
        chk("lat_in_ready_back", {31'd0, in_ready}, 32'd1);

        // Backpressure: result held 5 cycles while a word is offered and refused.
        out_ready = 1'b0;
        frame(8'h01, 8'h03, 8'h00, 8'hFF, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h07;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_parity", {31'd0, out_parity}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        chk("bp_frame_cnt", {24'd0, frame_cnt}, 32'd2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {31'd0, out_valid}, 32'd0);
        frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b1);

        // Reset mid-frame: partial frame discarded, count restarts.
        send(8'h01); send(8'h01);
        do_reset();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("mid_rst_one_frame", {24'd0, frame_cnt}, 32'd1);

        // Wrap: 256 zero frames bring frame_cnt back to 0.
        @(posedge clk); #1;
        do_reset();
        for (int f = 0; f < 256; f++) frame(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("wrap_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        chk("wrap_valid", {31'd0, out_valid}, 32'd1);

`ifdef PARITY_CHECK_EN
        @(posedge clk); #1;
        do_reset();
        exp_parity = 1'b0;
        frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("err_set", {31'd0, err}, 32'd1);
        chk("err_sticky_set", {31'd0, err_sticky}, 32'd1);
        exp_parity = 1'b1;
        frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("err_clear", {31'd0, err}, 32'd0);
        chk("err_sticky_held", {31'd0, err_sticky}, 32'd1);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", q_par.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_parity_acc.md
STREAM_PARITY_ACC -- requirements
Module: stream_parity_acc

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits, legal range 1..64.
REQ-002 The block SHALL have parameter FRAME_LEN, default 4: words per parity frame, legal range 1..256.
REQ-003 The block SHALL have parameter ODD, default 0: 0 selects even parity, 1 selects odd parity.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1: in_data holds a word.
REQ-007 The block SHALL have port in_data, input, WIDTH: data word.
REQ-008 The block SHALL have port in_ready, output, 1: the block can accept a word.
REQ-009 The block SHALL have port out_valid, output, 1: a frame parity result is presented.
REQ-010 The block SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-011 The block SHALL have port out_parity, output, 1: frame parity result.
REQ-012 The block SHALL have port frame_cnt, output, 8: number of completed frames, modulo 256.

Function
REQ-013 The block SHALL implement a state machine with exactly two states, ACC and HOLD.
REQ-014 In ACC, in_ready SHALL be 1; in HOLD, in_ready SHALL be 0.
REQ-015 A word SHALL be accepted on any cycle where in_valid and in_ready are both 1; otherwise acc and cnt SHALL hold.
REQ-016 On each accept that is not the last word of a frame (cnt != FRAME_LEN-1): acc <= acc XOR (XOR-reduction of in_data), and cnt <= cnt+1.
REQ-017 On accept of the last word (cnt == FRAME_LEN-1), on the same edge:
  - out_parity <= acc XOR reduce(in_data) XOR ODD
  - out_valid <= 1
  - acc <= 0, cnt <= 0
  - frame_cnt <= frame_cnt+1, wrapping 255 to 0
  - state <= HOLD
REQ-018 Latency SHALL be 1 cycle: out_valid is high in the cycle after the last word is accepted.
REQ-019 In HOLD, out_parity and out_valid SHALL remain stable until out_ready is 1. On that edge, out_valid <= 0 and state <= ACC.
REQ-020 Because in_ready is 0 in HOLD, the first word of the next frame SHALL NOT be accepted in the handshake cycle. The minimum frame-to-frame gap is therefore one cycle.
REQ-021 out_ready SHALL be ignored in ACC.
REQ-022 in_data SHALL be ignored whenever no accept occurs.
REQ-023 With FRAME_LEN=1, every accepted word SHALL complete a frame.
REQ-024 cnt SHALL be ceil(log2(FRAME_LEN)) bits wide, minimum 1 bit.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL set: state=ACC, acc=0, cnt=0, out_valid=0, out_parity=0, frame_cnt=0. This gives in_ready=1 after reset.
REQ-026 rst SHALL take priority over every other event, including reset mid-frame and reset during HOLD. Partial-frame data SHALL be discarded, and no result SHALL be emitted for it.

Configuration
REQ-027 With macro PARITY_CHECK_EN defined, the block SHALL add the following ports:
  - exp_parity, input, 1: sampled on the last-word accept
  - err, output, 1: registered with out_parity; 1 iff exp_parity != computed out_parity; held in HOLD
  - err_sticky, output, 1: set whenever err is set; cleared only by rst
REQ-028 With PARITY_CHECK_EN defined, err and err_sticky SHALL reset to 0.
REQ-029 Without PARITY_CHECK_EN, exp_parity, err and err_sticky, and their logic, SHALL be absent. All other behaviour SHALL be identical.

Verification
All scenarios use WIDTH=8, FRAME_LEN=4 unless stated otherwise.
REQ-030 ODD=0: words 0x01, 0x03, 0x00, 0xFF with in_valid continuous, out_ready=1 -> out_valid=1, out_parity=1, frame_cnt=1 one cycle after the 4th accept; out_valid=0 the next cycle.
REQ-031 ODD=1, same words -> out_parity=0.
REQ-032 Backpressure: out_ready=0 for 5 cycles after the result -> out_valid/out_parity stable and in_ready=0 throughout; a word driven meanwhile is not accepted, and acc and cnt are unchanged.
REQ-033 Reset mid-frame: accept 0x01, 0x01, assert rst for 1 cycle, then send 0x01, 0x00, 0x00, 0x00 -> exactly one result, out_parity=1, frame_cnt=1.
REQ-034 Wrap: 256 frames of 4x 0x00, out_ready=1 -> frame_cnt reads 0 after frame 256; every out_parity=0.
REQ-035 PARITY_CHECK_EN defined: frame 0x01, 0x00, 0x00, 0x00 with exp_parity=0 -> err=1 and err_sticky=1; next frame with matching exp_parity -> err=0 and err_sticky=1.
